// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, Kulisch accumulator defaults and the result flag type.
package fp16_pkg;

    localparam int FP16_EWIDTH     = 5;
    localparam int FP16_MWIDTH     = 10;
    localparam int FP16_BIAS       = 15;
    localparam int KULISCH_AWIDTH  = 91;
    localparam int KULISCH_LSB_EXP = 48;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp16_flags_t;

endpackage

// File: rtl/lzc_kulisch.sv
// Leading-one detector for the Kulisch magnitude: index of the highest set bit plus a zero flag.
module lzc_kulisch
    import fp16_pkg::*;
#(
    parameter int AWIDTH = KULISCH_AWIDTH,
    parameter int PW     = $clog2(AWIDTH)
) (
    input  logic [AWIDTH-1:0] i_data,
    output logic [PW-1:0]     o_pos,
    output logic              o_zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < AWIDTH; i++) begin
            if (i_data[i]) begin
                o_pos = PW'(i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/kulisch_fp16_round.sv
// Kulisch accumulator to IEEE-754 binary16 (RNE) converter, 2-stage valid/ready pipeline.
// Define KULISCH_SAT_EN to saturate overflow to +/-65504 instead of +/-infinity.
module kulisch_fp16_round
    import fp16_pkg::*;
#(
    parameter int AWIDTH  = KULISCH_AWIDTH,
    parameter int LSB_EXP = KULISCH_LSB_EXP,
    parameter int DWIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] i_acc,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DWIDTH-1:0] o_fp,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [2:0]        o_flags
);

    // Assumes LSB_EXP >= 24 so the 2^-24 quantum is a real accumulator bit.
    localparam int PW    = $clog2(AWIDTH);
    localparam int EMIN  = 1 - FP16_BIAS;
    localparam int EMAX  = FP16_BIAS;
    localparam int SUB_Q = LSB_EXP - 24;
    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

`ifdef KULISCH_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_ready, s2_ready, s1_fire, s1_move;

    assign s2_ready = ~s2_valid_q | i_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign s1_fire  = i_valid & s1_ready;
    assign s1_move  = s1_valid_q & s2_ready;
    assign o_ready  = s1_ready;

    // Stage 1: sign, magnitude, leading one
    logic              s1_sign_q, s1_sign_d;
    logic [AWIDTH-1:0] s1_mag_q, s1_mag_d;
    logic [PW-1:0]     s1_pos_q, s1_pos_d;
    logic              s1_zero_q, s1_zero_d;
    logic              s1_ovf_q, s1_ovf_d;

    logic              acc_neg;
    logic [AWIDTH-1:0] acc_mag;
    logic [PW-1:0]     lzc_pos;
    logic              lzc_zero;

    assign acc_neg = i_acc[AWIDTH-1];
    assign acc_mag = acc_neg ? (~i_acc + ONE) : i_acc;

    lzc_kulisch #(
        .AWIDTH (AWIDTH),
        .PW     (PW)
    ) u_lzc (
        .i_data (acc_mag),
        .o_pos  (lzc_pos),
        .o_zero (lzc_zero)
    );

    always_comb begin
        s1_valid_d = s1_ready ? i_valid : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_pos_d   = s1_pos_q;
        s1_zero_d  = s1_zero_q;
        s1_ovf_d   = s1_ovf_q;
        if (s1_fire) begin
            s1_sign_d = acc_neg;
            s1_mag_d  = acc_mag;
            s1_pos_d  = lzc_pos;
            s1_zero_d = lzc_zero;
            // The most negative value has no positive counterpart.
            s1_ovf_d  = acc_neg & ~|i_acc[AWIDTH-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b1;
            s1_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_pos_q   <= s1_pos_d;
            s1_zero_q  <= s1_zero_d;
            s1_ovf_q   <= s1_ovf_d;
        end
    end

    // Stage 2: shift, round, pack
    int                exp_unb;
    int                q_idx;
    logic              is_sub;
    logic [AWIDTH-1:0] low_mask;
    logic [11:0]       kept;
    logic              guard, sticky, inexact, round_up;
    logic [11:0]       rnd;
    logic [5:0]        bexp;
    logic [15:0]       res16;
    fp16_flags_t       res_flags;

    always_comb begin
        exp_unb = int'(s1_pos_q) - LSB_EXP;
        is_sub  = exp_unb < EMIN;
        // Bit index of the result LSB inside the accumulator.
        q_idx   = is_sub ? SUB_Q : int'(s1_pos_q) - FP16_MWIDTH;
        if (q_idx < 0) begin
            q_idx = 0;
        end
        low_mask = (ONE << q_idx) - ONE;
        kept     = 12'(s1_mag_q >> q_idx);
        guard    = |(s1_mag_q & (low_mask ^ (low_mask >> 1)));
        sticky   = |(s1_mag_q & (low_mask >> 1));
        inexact  = |(s1_mag_q & low_mask);
        round_up = guard & (sticky | kept[0]);
        rnd      = kept + 12'(round_up);
        bexp     = 6'(exp_unb + FP16_BIAS) + 6'(rnd[11]);
    end

    always_comb begin
        res16     = '0;
        res_flags = '0;
        if (s1_zero_q) begin
            res16 = '0;
        end else if (s1_ovf_q || exp_unb > EMAX) begin
            res16               = {s1_sign_q, OVF_MAG};
            res_flags.overflow  = 1'b1;
            res_flags.inexact   = 1'b1;
        end else if (is_sub) begin
            // A carry into bit 10 lands exactly on the smallest normal encoding.
            res16               = {s1_sign_q, 4'b0000, rnd[10:0]};
            res_flags.underflow = ~|rnd[10:0];
            res_flags.inexact   = inexact;
        end else if (bexp >= 6'd31) begin
            res16               = {s1_sign_q, OVF_MAG};
            res_flags.overflow  = 1'b1;
            res_flags.inexact   = 1'b1;
        end else begin
            res16             = {s1_sign_q, bexp[4:0], rnd[11] ? 10'b0 : rnd[9:0]};
            res_flags.inexact = inexact;
        end
    end

    logic [DWIDTH-1:0] s2_fp_q, s2_fp_d;
    fp16_flags_t       s2_flags_q, s2_flags_d;

    always_comb begin
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s2_fp_d    = s2_fp_q;
        s2_flags_d = s2_flags_q;
        if (s1_move) begin
            s2_fp_d    = DWIDTH'(res16);
            s2_flags_d = res_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_fp_q    <= '0;
            s2_flags_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_fp_q    <= s2_fp_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign o_valid = s2_valid_q;
    assign o_fp    = s2_fp_q;
    assign o_flags = s2_flags_q;

endmodule

// File: tb/tb_kulisch_fp16_round.sv
// Self-checking bench for kulisch_fp16_round against an arithmetic rounding model.
module tb_kulisch_fp16_round;

    logic        clk;
    logic        rst_n;
    logic [90:0] i_acc;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_fp;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_flags;

    int checks = 0;
    int errors = 0;

`ifdef KULISCH_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    kulisch_fp16_round dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_acc   (i_acc),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_fp    (o_fp),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_flags (o_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // value = acc * 2^-48; round to the binary16 grid with ties to even
    function automatic void ref_round(input logic [90:0] acc, output logic [15:0] fp,
                                      output logic [2:0] fl);
        logic signed [127:0] sa;
        logic [127:0] mag, den, n, r;
        int p, eq;
        logic sgn, inex;
        sa  = {{37{acc[90]}}, acc};
        sgn = acc[90];
        mag = sgn ? 128'(-sa) : 128'(sa);
        fp  = 16'h0000;
        fl  = 3'b000;
        if (mag == 128'd0) return;
        p = 0;
        for (int k = 0; k < 128; k++) begin
            if (mag >= (128'd1 << k)) p = k;
        end
        eq = p - 48;
        if (eq > 15) begin
            fp = {sgn, OVF_MAG};
            fl = 3'b101;
            return;
        end
        if (eq < -14) eq = -14;
        den  = 128'd1 << (eq - 10 + 48);
        n    = mag / den;
        r    = mag % den;
        inex = (r != 128'd0);
        if ((2 * r > den) || ((2 * r == den) && n[0])) n = n + 128'd1;
        if (n == 128'd0) begin
            fp = {sgn, 15'h0000};
            fl = 3'b011;
            return;
        end
        if (n == 128'd2048) begin
            n  = 128'd1024;
            eq = eq + 1;
        end
        if (eq > 15) begin
            fp = {sgn, OVF_MAG};
            fl = 3'b101;
            return;
        end
        if (n >= 128'd1024) fp = {sgn, 5'(eq + 15), n[9:0]};
        else fp = {sgn, 5'b00000, n[9:0]};
        fl = {2'b00, inex};
    endfunction

    function automatic logic [90:0] rand_acc();
        logic [95:0] r;
        logic [90:0] m;
        int c, k;
        r = {$urandom, $urandom, $urandom};
        c = $urandom_range(0, 9);
        case (c)
            0: m = '0;
            1: return {1'b1, 90'b0};
            2: m = (91'd65504 << 48) + 91'(r[52:0]);
            3: begin
                k = $urandom_range(0, 70);
                m = 91'({1'b1, r[9:0], 1'b1}) << k;
            end
            default: begin
                k = $urandom_range(1, 72);
                m = 91'(r) & ((91'd1 << k) - 91'd1);
            end
        endcase
        if (r[95]) m = -m;
        return m;
    endfunction

    task automatic send_one(input logic [90:0] acc, input logic [15:0] efp,
                            input logic [2:0] efl, input string name);
        int lat;
        i_acc   = acc;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: o_ready got %b expected 1", name, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat     = 1;
        @(negedge clk);
        while (o_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 2", name, lat);
        end
        checks++;
        if (o_fp !== efp) begin
            errors++;
            $display("FAIL %s o_fp: got %h expected %h", name, o_fp, efp);
        end
        checks++;
        if (o_flags !== efl) begin
            errors++;
            $display("FAIL %s o_flags: got %b expected %b", name, o_flags, efl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input bit b2b, input string name);
        logic [18:0] exp_q[$];
        logic [90:0] pend;
        logic [15:0] efp;
        logic [2:0]  efl;
        logic        exp_rdy;
        int sent, got, cyc, inflight;
        sent = 0;
        got  = 0;
        cyc  = 0;
        pend = rand_acc();
        while ((sent < n || got < sent) && cyc < 5000) begin
            i_acc   = pend;
            i_valid = (sent < n) && (b2b || ($urandom_range(0, 3) != 0));
            i_ready = b2b ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            inflight = sent - got;
            exp_rdy  = !(inflight == 2 && !i_ready);
            checks++;
            if (o_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s o_ready cyc %0d: got %b expected %b", name, cyc, o_ready,
                         exp_rdy);
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s spurious o_valid cyc %0d: got %h expected none", name,
                             cyc, o_fp);
                end else if ({o_fp, o_flags} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s result cyc %0d: got %h/%b expected %h/%b", name, cyc,
                             o_fp, o_flags, exp_q[0][18:3], exp_q[0][2:0]);
                end
                if (i_ready) begin
                    got++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            if (i_valid && o_ready) begin
                ref_round(pend, efp, efl);
                exp_q.push_back({efp, efl});
                sent++;
                pend = rand_acc();
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        checks++;
        if (sent != n || got != n) begin
            errors++;
            $display("FAIL %s count: got sent %0d delivered %0d expected %0d", name, sent,
                     got, n);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_acc   = '0;
        #3;
        checks += 4;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL reset o_valid: got %b expected 0", o_valid);
        end
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL reset o_ready: got %b expected 1", o_ready);
        end
        if (o_fp !== 16'h0000) begin
            errors++; $display("FAIL reset o_fp: got %h expected 0000", o_fp);
        end
        if (o_flags !== 3'b000) begin
            errors++; $display("FAIL reset o_flags: got %b expected 000", o_flags);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [90:0] a[13];
        logic [15:0] f[13];
        logic [2:0]  g[13];
        a[0]  = 91'd1 << 48;                  f[0]  = 16'h3C00; g[0]  = 3'b000;
        a[1]  = -(91'd1 << 48);               f[1]  = 16'hBC00; g[1]  = 3'b000;
        a[2]  = (91'd1 << 48) + (91'd1 << 37); f[2]  = 16'h3C00; g[2]  = 3'b001;
        a[3]  = (91'd1 << 48) + (91'd3 << 37); f[3]  = 16'h3C02; g[3]  = 3'b001;
        a[4]  = 91'd1 << 24;                  f[4]  = 16'h0001; g[4]  = 3'b000;
        a[5]  = 91'd1 << 23;                  f[5]  = 16'h0000; g[5]  = 3'b011;
        a[6]  = 91'd0;                        f[6]  = 16'h0000; g[6]  = 3'b000;
        a[7]  = 91'd1 << 64;                  f[7]  = {1'b0, OVF_MAG}; g[7] = 3'b101;
        a[8]  = (91'd65504 << 48) + (91'd1 << 42); f[8] = 16'h7BFF; g[8] = 3'b001;
        a[9]  = -(91'd1 << 23);               f[9]  = 16'h8000; g[9]  = 3'b011;
        a[10] = 91'd1 << 34;                  f[10] = 16'h0400; g[10] = 3'b000;
        a[11] = (91'd1 << 34) - 91'd1;        f[11] = 16'h0400; g[11] = 3'b001;
        a[12] = {1'b1, 90'b0};                f[12] = {1'b1, OVF_MAG}; g[12] = 3'b101;
        for (int i = 0; i < 13; i++) begin
            send_one(a[i], f[i], g[i], $sformatf("dir%0d", i));
        end
    endtask

    task automatic test_random();
        run_stream(300, 1'b0, "rand");
    endtask

    task automatic test_back_to_back();
        run_stream(8, 1'b1, "b2b");
    endtask

    task automatic test_reset_midflight();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_acc   = 91'd1 << 48;
        @(posedge clk);
        #1;
        i_acc = 91'd3 << 48;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++; $display("FAIL midrst setup o_valid: got %b expected 1", o_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL midrst o_valid: got %b expected 0", o_valid);
        end
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL midrst o_ready: got %b expected 1", o_ready);
        end
        if (o_fp !== 16'h0000) begin
            errors++; $display("FAIL midrst o_fp: got %h expected 0000", o_fp);
        end
        if (o_flags !== 3'b000) begin
            errors++; $display("FAIL midrst o_flags: got %b expected 000", o_flags);
        end
        i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_one(-(91'd5 << 46), 16'hBD00, 3'b000, "midrst_first");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL midrst stale o_valid: got %b expected 0", o_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
